// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM port arbiter for VGA scan-out. Read slots are fixed: one per
// 4-pixel group in active video. Every other cycle is a write slot, used by the
// pixel writer in IDLE or by the clear-screen engine in CLEAR.
`timescale 1ns/1ps
module vga_fb_arbiter #(
   parameter int unsigned FB_W   = 160,
   parameter int unsigned FB_H   = 120,
   parameter int unsigned ADDR_W = 15
) (
   input  logic              clk_25MHz,
   input  logic              rst,
   input  logic [9:0]        i_x,
   input  logic [9:0]        i_y,
   input  logic              i_de,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [11:0]       i_wr_data,
   output logic              o_wr_ready,
   input  logic              i_clear,
   input  logic [11:0]       i_clear_color,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic              o_ram_we,
   output logic [11:0]       o_ram_wdata,
   input  logic [11:0]       i_ram_rdata,
   output logic [3:0]        o_red,
   output logic [3:0]        o_green,
   output logic [3:0]        o_blue,
   output logic              o_de_d,
   output logic [7:0]        o_drop_cnt
);

   localparam int unsigned       FbWords  = FB_W * FB_H;
   localparam logic [ADDR_W-1:0] WordsLim = ADDR_W'(FbWords);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FbWords - 1);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [11:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [11:0]       clr_col_q, clr_col_d;
   logic [7:0]        drop_q, drop_d;

   logic [2:0]        de_pipe_q;
   logic [1:0]        rd_pipe_q;
   logic [11:0]       pix_q;
   logic [11:0]       rgb_q;

   logic              read_slot;
   logic              write_slot;
   logic              accept;
   logic              in_range;
   logic [ADDR_W-1:0] rd_row;
   logic [ADDR_W-1:0] rd_col;
   logic [ADDR_W-1:0] rd_addr;

   // Slot decode: first pixel of each 4-pixel group in active video reads.
   assign read_slot  = i_de && (i_x[1:0] == 2'b00);
   assign write_slot = ~read_slot;

   // Frame-buffer address of the upscaled pixel: row*160 + col via shift-add.
   assign rd_row  = ADDR_W'(i_y[9:2]);
   assign rd_col  = ADDR_W'(i_x[9:2]);
   assign rd_addr = (rd_row << 7) + (rd_row << 5) + rd_col;

   // Writer may proceed only in IDLE on a write slot, never while held in reset.
   assign o_wr_ready = rst && (state_q == StIdle) && write_slot;
   assign accept     = i_wr_valid && o_wr_ready;
   assign in_range   = i_wr_addr < WordsLim;

   // Next-state: RAM command, clear engine and drop counter.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      we_d      = 1'b0;
      wdata_d   = wdata_q;
      clr_cnt_d = clr_cnt_q;
      clr_col_d = clr_col_q;
      drop_d    = drop_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_range) begin
                  we_d    = 1'b1;
                  addr_d  = i_wr_addr;
                  wdata_d = i_wr_data;
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
            if (i_clear) begin
               state_d   = StClear;
               clr_col_d = i_clear_color;
               clr_cnt_d = '0;
            end
         end
         StClear: begin
            if (write_slot) begin
               we_d      = 1'b1;
               addr_d    = clr_cnt_q;
               wdata_d   = clr_col_q;
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
               if (clr_cnt_q == LastAddr) begin
                  state_d   = StIdle;
                  clr_cnt_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Scan-out read always owns the port on its slot.
      if (read_slot) begin
         addr_d = rd_addr;
         we_d   = 1'b0;
      end
   end

   // State and registered RAM command.
   always_ff @(posedge clk_25MHz or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         clr_cnt_q <= '0;
         clr_col_q <= '0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         clr_cnt_q <= clr_cnt_d;
         clr_col_q <= clr_col_d;
         drop_q    <= drop_d;
      end
   end

   // Scan-out pipeline: read data returns two cycles after the slot, colour
   // register loads from it directly so output lands three cycles after the slot.
   always_ff @(posedge clk_25MHz or negedge rst) begin
      if (!rst) begin
         de_pipe_q <= '0;
         rd_pipe_q <= '0;
         pix_q     <= '0;
         rgb_q     <= '0;
      end else begin
         de_pipe_q <= {de_pipe_q[1:0], i_de};
         rd_pipe_q <= {rd_pipe_q[0], read_slot};
         if (rd_pipe_q[1]) begin
            pix_q <= i_ram_rdata;
         end
         if (de_pipe_q[1]) begin
            rgb_q <= rd_pipe_q[1] ? i_ram_rdata : pix_q;
         end else begin
            rgb_q <= '0;
         end
      end
   end

   assign o_busy      = (state_q == StClear);
   assign o_ram_addr  = addr_q;
   assign o_ram_we    = we_q;
   assign o_ram_wdata = wdata_q;
   assign o_drop_cnt  = drop_q;
   assign o_de_d      = de_pipe_q[2];
   assign o_red       = rgb_q[11:8];
   assign o_green     = rgb_q[7:4];
   assign o_blue      = rgb_q[3:0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter against a frame-buffer level reference model.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

   localparam int FbW   = 160;
   localparam int Words = 19200;
   localparam int AW    = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [9:0]    i_x = '0;
   logic [9:0]    i_y = '0;
   logic          i_de = 1'b0;
   logic          i_wr_valid = 1'b0;
   logic [AW-1:0] i_wr_addr = '0;
   logic [11:0]   i_wr_data = '0;
   logic          o_wr_ready;
   logic          i_clear = 1'b0;
   logic [11:0]   i_clear_color = '0;
   logic          o_busy;
   logic [AW-1:0] o_ram_addr;
   logic          o_ram_we;
   logic [11:0]   o_ram_wdata;
   logic [11:0]   i_ram_rdata = '0;
   logic [3:0]    o_red, o_green, o_blue;
   logic          o_de_d;
   logic [7:0]    o_drop_cnt;

   always #20 clk = ~clk;

   vga_fb_arbiter dut (
      .clk_25MHz     (clk),
      .rst           (rst),
      .i_x           (i_x),
      .i_y           (i_y),
      .i_de          (i_de),
      .i_wr_valid    (i_wr_valid),
      .i_wr_addr     (i_wr_addr),
      .i_wr_data     (i_wr_data),
      .o_wr_ready    (o_wr_ready),
      .i_clear       (i_clear),
      .i_clear_color (i_clear_color),
      .o_busy        (o_busy),
      .o_ram_addr    (o_ram_addr),
      .o_ram_we      (o_ram_we),
      .o_ram_wdata   (o_ram_wdata),
      .i_ram_rdata   (i_ram_rdata),
      .o_red         (o_red),
      .o_green       (o_green),
      .o_blue        (o_blue),
      .o_de_d        (o_de_d),
      .o_drop_cnt    (o_drop_cnt)
   );

   // Single-port synchronous RAM.
   logic [11:0] mem [0:Words-1];
   always @(posedge clk) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
      i_ram_rdata <= mem[o_ram_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Stimulus as plain integers.
   int s_x, s_y, s_de, s_valid, s_addr, s_data, s_clr, s_ccol;

   // Reference model: expected frame-buffer contents and port activity.
   int gold [Words];
   int m_busy, m_idx, m_col, m_drops;
   int m_addr, m_we, m_wdata, m_pix;
   int pipe_de [3];
   int pipe_col [3];
   int m_undo, m_undo_addr, m_undo_data;

   task automatic drive();
      i_x           = 10'(s_x);
      i_y           = 10'(s_y);
      i_de          = (s_de != 0);
      i_wr_valid    = (s_valid != 0);
      i_wr_addr     = AW'(s_addr);
      i_wr_data     = 12'(s_data);
      i_clear       = (s_clr != 0);
      i_clear_color = 12'(s_ccol);
   endtask

   task automatic model_reset();
      m_busy = 0; m_idx = 0; m_col = 0; m_drops = 0;
      m_addr = 0; m_we = 0; m_wdata = 0; m_pix = 0; m_undo = 0;
      for (int i = 0; i < 3; i++) begin
         pipe_de[i]  = 0;
         pipe_col[i] = 0;
      end
   endtask

   // One clock: drive, predict, then check registered outputs after the edge.
   task automatic tick();
      int rd, busy0, col_s;
      drive();
      @(negedge clk);
      rd    = (s_de != 0 && (s_x % 4) == 0) ? 1 : 0;
      busy0 = m_busy;
      check_eq("wr_ready", 32'(o_wr_ready), (busy0 == 0 && rd == 0) ? 1 : 0);
      m_we   = 0;
      m_undo = 0;
      if (rd != 0) begin
         m_addr = (s_y / 4) * FbW + s_x / 4;
         m_pix  = gold[m_addr];
      end else if (busy0 != 0) begin
         m_we = 1; m_addr = m_idx; m_wdata = m_col;
         m_idx++;
         if (m_idx == Words) m_busy = 0;
      end else if (s_valid != 0) begin
         if (s_addr < Words) begin
            m_we = 1; m_addr = s_addr; m_wdata = s_data;
         end else if (m_drops < 255) begin
            m_drops++;
         end
      end
      if (busy0 == 0 && s_clr != 0) begin
         m_busy = 1; m_idx = 0; m_col = s_ccol;
      end
      if (m_we != 0) begin
         m_undo = 1; m_undo_addr = m_addr; m_undo_data = gold[m_addr];
         gold[m_addr] = m_wdata;
      end
      col_s = (s_de != 0) ? m_pix : 0;
      pipe_de[2] = pipe_de[1];  pipe_col[2] = pipe_col[1];
      pipe_de[1] = pipe_de[0];  pipe_col[1] = pipe_col[0];
      pipe_de[0] = s_de;        pipe_col[0] = col_s;
      @(posedge clk);
      #1;
      check_eq("ram_we", 32'(o_ram_we), m_we);
      check_eq("ram_addr", 32'(o_ram_addr), m_addr);
      if (m_we != 0) check_eq("ram_wdata", 32'(o_ram_wdata), m_wdata);
      check_eq("busy", 32'(o_busy), m_busy);
      check_eq("drop_cnt", 32'(o_drop_cnt), m_drops);
      check_eq("de_d", 32'(o_de_d), (pipe_de[2] != 0) ? 1 : 0);
      check_eq("rgb", 32'({o_red, o_green, o_blue}), pipe_col[2]);
   endtask

   // Asynchronous reset asserted mid-cycle, held for n edges, released mid-cycle.
   task automatic apply_reset(input int n);
      rst = 1'b0;
      drive();
      #1;
      if (m_undo != 0) gold[m_undo_addr] = m_undo_data;
      model_reset();
      check_eq("rst_busy", 32'(o_busy), 0);
      check_eq("rst_we", 32'(o_ram_we), 0);
      check_eq("rst_addr", 32'(o_ram_addr), 0);
      check_eq("rst_wdata", 32'(o_ram_wdata), 0);
      check_eq("rst_rgb", 32'({o_red, o_green, o_blue}), 0);
      check_eq("rst_de_d", 32'(o_de_d), 0);
      check_eq("rst_drop", 32'(o_drop_cnt), 0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         check_eq("rst_ready", 32'(o_wr_ready), 0);
         check_eq("rst_hold_we", 32'(o_ram_we), 0);
         check_eq("rst_hold_busy", 32'(o_busy), 0);
      end
      rst = 1'b1;
   endtask

   task automatic idle_inputs();
      s_x = 0; s_y = 0; s_de = 0; s_valid = 0; s_addr = 0; s_data = 0; s_clr = 0; s_ccol = 0;
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < Words; i++) gold[i] = 0;
      model_reset();
      idle_inputs();

      // Reset with active requests pending.
      s_valid = 1; s_addr = 42; s_data = 'h777; s_clr = 1; s_ccol = 'h321;
      #5;
      apply_reset(4);
      rst = 1'b0;
      idle_inputs();
      drive();
      rst = 1'b1;
      repeat (5) tick();

      // Preload pixel (row 1, col 1) and scan it out.
      s_valid = 1; s_addr = 161; s_data = 'hF0A;
      tick();
      s_valid = 0;
      repeat (2) tick();
      s_de = 1; s_y = 4;
      for (int x = 4; x < 8; x++) begin
         s_x = x;
         tick();
      end
      s_de = 0; s_x = 0; s_y = 0;
      repeat (6) tick();

      // Out-of-range write then the last legal address.
      s_valid = 1; s_addr = 19200; s_data = 'h111;
      tick();
      check_eq("drop_one", 32'(o_drop_cnt), 1);
      s_addr = 19199; s_data = 'h5A5;
      tick();
      check_eq("last_addr_we", 32'(o_ram_we), 1);
      s_valid = 0;
      tick();

      // Full clear in blanking, with a second request mid-run ignored.
      s_clr = 1; s_ccol = 'h123;
      tick();
      s_clr = 0;
      n = 0;
      while (m_busy != 0 && n < 25000) begin
         s_valid = $urandom_range(0, 1);
         s_addr  = $urandom_range(0, Words - 1);
         s_data  = $urandom_range(0, 4095);
         s_clr   = (m_idx == 9000) ? 1 : 0;
         s_ccol  = 'hABC;
         tick();
         n++;
      end
      s_clr = 0; s_valid = 0;
      check_eq("clear_done", 32'(o_busy), 0);
      check_eq("clear_words", 32'(m_idx), Words);
      repeat (3) tick();

      // Random traffic over several scan lines with blanking.
      for (int line = 0; line < 6; line++) begin
         s_y = $urandom_range(0, 479);
         for (int h = 0; h < 800; h++) begin
            s_de    = (h < 640) ? 1 : 0;
            s_x     = (h < 640) ? h : $urandom_range(0, 639);
            s_valid = ($urandom_range(0, 3) != 0) ? 1 : 0;
            s_addr  = ($urandom_range(0, 15) == 0) ? $urandom_range(Words, 32767)
                                                  : $urandom_range(0, Words - 1);
            s_data  = $urandom_range(0, 4095);
            tick();
         end
      end
      idle_inputs();
      repeat (4) tick();

      // Drop counter saturation.
      for (int i = 0; i < 300; i++) begin
         s_valid = 1;
         s_addr  = $urandom_range(Words, 32767);
         tick();
      end
      s_valid = 0;
      tick();
      check_eq("drop_sat", 32'(o_drop_cnt), 255);

      // Reset in the middle of a clear.
      s_clr = 1; s_ccol = 'h456;
      tick();
      s_clr = 0;
      n = 0;
      while (m_idx < 5000 && n < 6000) begin
         tick();
         n++;
      end
      check_eq("mid_clear_busy", 32'(o_busy), 1);
      apply_reset(3);
      repeat (50) tick();
      check_eq("post_reset_idle", 32'(o_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Time-slot arbiter and sequencer for the single-port frame-buffer RAM that feeds the VGA scan-out path. Shares one RAM port between the display reader (hard real-time, fixed slots) and a pixel writer (valid/ready), and runs a built-in clear-screen engine. Sits between the VGA timing generator (supplies active-area x/y and display-enable) and the 4-bit-per-channel colour outputs. Frame buffer is 160x120 x 12-bit, upscaled 4x to 640x480.

## Interface
- FB_W, 160, frame-buffer width in pixels
- FB_H, 120, frame-buffer height in pixels
- ADDR_W, 15, RAM address width (FB_W*FB_H = 19200 words)
- clk_25MHz  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- i_x  in  10  active-area column 0..639, valid when i_de=1
- i_y  in  10  active-area row 0..479, valid when i_de=1
- i_de  in  1  display enable from timing generator
- i_wr_valid  in  1  writer request
- i_wr_addr  in  ADDR_W  writer word address (row*160+col)
- i_wr_data  in  12  writer colour {R,G,B}
- o_wr_ready  out  1  writer slot available this cycle
- i_clear  in  1  single-cycle pulse: start clear-screen
- i_clear_color  in  12  fill colour, sampled with i_clear
- o_busy  out  1  clear engine active
- o_ram_addr  out  ADDR_W  RAM address, registered
- o_ram_we  out  1  RAM write enable, registered
- o_ram_wdata  out  12  RAM write data, registered
- i_ram_rdata  in  12  RAM read data, valid 1 cycle after o_ram_addr
- o_red, o_green, o_blue  out  4 each  pixel colour, 0 outside display
- o_de_d  out  1  i_de delayed 3 cycles
- o_drop_cnt  out  8  saturating count of dropped out-of-range writes

## Operation
- Read slot: cycle with i_de=1 and i_x[1:0]=0. Every other cycle is a write slot.
- Read slot: next cycle o_ram_addr = (i_y>>2)*160 + (i_x>>2), o_ram_we=0. Multiply by shift-add ((r<<7)+(r<<5)), ADDR_W bits, no overflow for legal inputs.
- Pixel register loads i_ram_rdata on the cycle data returns; held for the 4-cycle group.
- o_red/o_green/o_blue = pixel register [11:8]/[7:4]/[3:0] when o_de_d=1, else 0; registered.
- FSM states IDLE, CLEAR.
- IDLE: o_wr_ready = write slot (combinational from i_de, i_x). On valid&&ready: if i_wr_addr < 19200, next cycle o_ram_we=1, addr/data = request; else no RAM write, o_drop_cnt increments (saturates at 255).
- IDLE -> CLEAR on i_clear=1: latch i_clear_color, clear counter = 0, o_busy=1 from next cycle.
- CLEAR: o_wr_ready=0. Each write slot writes latched colour to clear counter, counter increments. After write to 19199 -> IDLE, o_busy=0 next cycle.
- i_clear while in CLEAR: ignored (no restart, colour unchanged).
- Write-slot cycles with no write: o_ram_we=0, o_ram_addr holds last value.

## Timing
- Reset (rst=0, async): state IDLE, o_ram_addr=0, o_ram_we=0, o_ram_wdata=0, colours=0, o_de_d=0, o_busy=0, o_drop_cnt=0, clear counter=0, pixel register=0; o_wr_ready=0 while rst=0.
- Reset mid-CLEAR: clear aborted, no further fill writes after release.
- Pixel latency: colour outputs at cycle T+3 correspond to i_x/i_y/i_de sampled at T. Timing generator delays hsync/vsync by 3 to match.
- Write latency: accepted at T -> o_ram_we=1 at T+1 only (single cycle).
- Read and write never on the same cycle; read slot always wins.
- Writer throughput: 3 of 4 cycles in active video, every cycle in blanking.
- Full clear of 19200 words completes within one 800x525 frame (>=14400 blanking slots plus active-area write slots).

## Test plan
- Reset: hold rst=0 with i_wr_valid=1, i_clear=1 -> all outputs 0, o_wr_ready=0, no RAM write after release until new request.
- Scan-out: preload RAM addr 161 = 12'hF0A; drive i_de=1, i_y=4, i_x=4..7 at T..T+3 -> o_ram_addr=161 at T+1, colours R=F,G=0,B=A at T+3..T+6, o_de_d=1.
- Slot arbitration: i_wr_valid=1 constant, i_de=1, i_x sweeping -> o_wr_ready=0 exactly when i_x[1:0]=0; writes at 3/4 rate; no cycle with o_ram_we=1 and read address issued together.
- Out-of-range: write i_wr_addr=19200 then 19199 -> first no o_ram_we, o_drop_cnt=1; second o_ram_we=1, addr 19199. 300 bad writes -> o_drop_cnt=255.
- Clear: i_clear with colour 12'h123 in blanking -> o_busy=1, 19200 consecutive writes addr 0..19199 data 12'h123, o_wr_ready=0 throughout, o_busy=0 after last; second i_clear mid-run ignored.
- Reset mid-clear: assert rst=0 at counter 5000 -> o_busy=0, o_ram_we=0 immediately; no writes after release.
